// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer, the 8-bit shifter and the bench:
// shifter opcodes, command kinds, FSM state encoding and step helpers.
package shift_sequencer_pkg;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int STEP = 3;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_LSL  = 3'b010,
        OP_LSR  = 3'b011,
        OP_ASR  = 3'b100
    } sh_op_e;

    typedef enum logic [1:0] {
        KIND_LSL  = 2'd0,
        KIND_LSR  = 2'd1,
        KIND_ASR  = 2'd2,
        KIND_RSVD = 2'd3
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Largest single shifter step that does not overshoot the remaining amount.
    function automatic logic [1:0] step_of(input logic [AW-1:0] rem);
        return (rem > AW'(STEP)) ? 2'(STEP) : rem[1:0];
    endfunction

    function automatic sh_op_e kind_to_op(input cmd_kind_e kind);
        case (kind)
            KIND_LSL: return OP_LSL;
            KIND_LSR: return OP_LSR;
            KIND_ASR: return OP_ASR;
            default:  return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command and result handshake bundle between a command source (master)
// and the shift sequencer (slave).
interface shift_sequencer_if;
    import shift_sequencer_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] cmd_amt;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_err;

    modport master (
        output cmd_valid, cmd_kind, cmd_data, cmd_amt, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_data, cmd_amt, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/shifter8.sv
// 8-bit registered shifter datapath: LOAD, LSL, LSR, ASR with a 2-bit shift
// amount per operation; NOP holds the register.
module shifter8
    import shift_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  sh_op_e        op_i,
    input  logic [1:0]    shamt_i,
    input  logic [DW-1:0] d_in_i,
    output logic [DW-1:0] d_out_o
);

    logic [DW-1:0] d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= '0;
        end else begin
            case (op_i)
                OP_LOAD: d_q <= d_in_i;
                OP_LSL:  d_q <= d_q << shamt_i;
                OP_LSR:  d_q <= d_q >> shamt_i;
                OP_ASR:  d_q <= $signed(d_q) >>> shamt_i;
                default: d_q <= d_q;
            endcase
        end
    end

    assign d_out_o = d_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-level controller for shifter8: loads the operand, then breaks the
// requested shift into steps of at most STEP bits and hands back the result.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    shift_sequencer_if.slave    bus,
    output sh_op_e              sh_op,
    output logic [1:0]          sh_shamt,
    output logic [DW-1:0]       sh_d_in,
    input  logic [DW-1:0]       sh_d_out
);

    state_e        state_q;
    cmd_kind_e     kind_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] rem_q;

    // Registered outputs, updated alongside the state they belong to.
    logic          cmd_ready_q;
    sh_op_e        sh_op_q;
    logic [1:0]    sh_shamt_q;
    logic          res_valid_q;
    logic          res_err_q;

    logic [1:0]    step_now;
    logic [AW-1:0] rem_d;

    // NOTE: every variable assigned here is assigned on every pass, so no latch can form.
    always_comb begin
        step_now = step_of(rem_q);
        rem_d    = rem_q - AW'(step_now);
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_LSL;
            data_q      <= '0;
            rem_q       <= '0;
            cmd_ready_q <= 1'b1;
            sh_op_q     <= OP_NOP;
            sh_shamt_q  <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        kind_q      <= cmd_kind_e'(bus.cmd_kind);
                        data_q      <= bus.cmd_data;
                        rem_q       <= bus.cmd_amt;
                        cmd_ready_q <= 1'b0;
                        if (cmd_kind_e'(bus.cmd_kind) == KIND_RSVD) begin
                            state_q     <= ST_DONE;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                            sh_op_q <= OP_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (rem_q != '0) begin
                        state_q    <= ST_SHIFT;
                        sh_op_q    <= kind_to_op(kind_q);
                        sh_shamt_q <= step_now;
                    end else begin
                        state_q     <= ST_DONE;
                        sh_op_q     <= OP_NOP;
                        res_valid_q <= 1'b1;
                    end
                end

                // sh_shamt_q always holds step_of(rem_q) while in SHIFT.
                ST_SHIFT: begin
                    rem_q <= rem_d;
                    if (rem_q <= AW'(STEP)) begin
                        state_q     <= ST_DONE;
                        sh_op_q     <= OP_NOP;
                        sh_shamt_q  <= '0;
                        res_valid_q <= 1'b1;
                    end else begin
                        sh_shamt_q <= step_of(rem_d);
                    end
                end

                ST_DONE: begin
                    if (bus.res_ready) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_err   = res_err_q;
    assign bus.res_data  = sh_d_out;

    assign sh_op    = sh_op_q;
    assign sh_shamt = sh_shamt_q;
    assign sh_d_in  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer driving shifter8: directed cases,
// a stalled result, reset mid-command and randomized back-to-back traffic.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_sequencer_if bus();

    sh_op_e     sh_op;
    logic [1:0] sh_shamt;
    logic [7:0] sh_d_in;
    logic [7:0] sh_d_out;

    shift_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sh_op    (sh_op),
        .sh_shamt (sh_shamt),
        .sh_d_in  (sh_d_in),
        .sh_d_out (sh_d_out)
    );

    shifter8 u_shifter (
        .clk     (clk),
        .reset   (reset),
        .op_i    (sh_op),
        .shamt_i (sh_shamt),
        .d_in_i  (sh_d_in),
        .d_out_o (sh_d_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        int         amt;
        logic [7:0] res;
        bit         err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb_q[$];

    // Result of shifting the whole amount in one go, using wide integers.
    function automatic logic [7:0] ref_result(input logic [1:0] k, input logic [7:0] d, input int a);
        int u;
        int s;
        u = {24'b0, d};
        s = {{24{d[7]}}, d};
        case (k)
            2'd0:    return 8'(u << a);
            2'd1:    return 8'(u >> a);
            2'd2:    return 8'(s >>> a);
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- result-ready driver ----------------
    int stall_left = 0;
    bit rdy_rand   = 0;

    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.res_ready = 1'b0;
                if (bus.res_valid) stall_left--;
            end else begin
                bus.res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t cur;
    int   seq[$];
    int   loads   = 0;
    bit   seen    = 0;
    int   last_hs = -100;
    int   illegal = 0;
    int   nexp;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                seq.delete();
                loads = 0;
                seen  = 0;
            end else begin
                if (sh_op > OP_ASR) illegal++;
                if (sb_q.size() == 0) begin
                    if (bus.res_valid) check("spurious_res_valid", bus.res_valid, 0);
                end else begin
                    cur = sb_q[0];
                    if (sh_op == OP_LOAD) begin
                        loads++;
                        check("sh_d_in", sh_d_in, cur.data);
                    end
                    if (sh_op inside {OP_LSL, OP_LSR, OP_ASR}) begin
                        check("sh_op_kind", sh_op, 3'(cur.kind) + 3'd2);
                        seq.push_back(int'(sh_shamt));
                    end
                    if (bus.res_valid) begin
                        if (!seen) begin
                            check("latency", cyc - cur.acc, cur.lat);
                            seen = 1;
                        end
                        check("cmd_ready_busy", bus.cmd_ready, 0);
                        check("res_err", bus.res_err, cur.err);
                        if (!cur.err) check("res_data", bus.res_data, cur.res);
                        if (bus.res_ready) begin
                            nexp = cur.err ? 0 : (cur.amt + 2) / 3;
                            check("shift_op_count", seq.size(), nexp);
                            for (int i = 0; i < seq.size() && i < nexp; i++)
                                check("shamt_seq", seq[i], (cur.amt - 3 * i > 3) ? 3 : cur.amt - 3 * i);
                            check("load_count", loads, cur.err ? 0 : 1);
                            void'(sb_q.pop_front());
                            seq.delete();
                            loads   = 0;
                            seen    = 0;
                            last_hs = cyc;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] k, input logic [7:0] d, input int a, output int acc);
        int   waited = 0;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = k;
        bus.cmd_data  = d;
        bus.cmd_amt   = 4'(a);
        acc = -1;
        while (acc < 0) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc   = cyc;
                e.kind = k;
                e.data = d;
                e.amt  = a;
                e.res  = ref_result(k, d, a);
                e.err  = (k == 2'd3);
                e.lat  = e.err ? 1 : 2 + (a + 2) / 3;
                e.acc  = cyc;
                sb_q.push_back(e);
            end else if (++waited > 200) begin
                check("accept_timeout", bus.cmd_ready, 1);
                acc = 0;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 2'($urandom);
        bus.cmd_data  = 8'($urandom);
        bus.cmd_amt   = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int acc_a, acc_b, n;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 2'd0;
        bus.cmd_data  = 8'h00;
        bus.cmd_amt   = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_sh_op", sh_op, OP_NOP);
        check("rst_sh_shamt", sh_shamt, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_err", bus.res_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases.
        send(2'd0, 8'h81, 1, acc_a);   wait_idle();
        send(2'd2, 8'h80, 7, acc_a);   wait_idle();
        send(2'd1, 8'hF0, 0, acc_a);   wait_idle();
        send(2'd0, 8'h01, 15, acc_a);  wait_idle();
        send(2'd3, 8'h5A, 9, acc_a);   wait_idle();

        // Result held off for 4 cycles, with the next command already waiting.
        stall_left = 4;
        send(2'd0, 8'h3C, 2, acc_a);
        send(2'd1, 8'h99, 4, acc_b);
        check("b2b_accept", acc_b, last_hs + 1);
        check("stall_span", acc_b - acc_a, 3 + 4 + 1);   // latency 3, 4 stalls, 1 handshake
        wait_idle();

        // Randomized back-to-back traffic with random result back-pressure.
        rdy_rand = 1;
        for (int i = 0; i < 60; i++)
            send(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 15), acc_a);
        wait_idle();
        rdy_rand = 0;

        // Reset during SHIFT; a command offered under reset must not be taken.
        send(2'd2, 8'h80, 9, acc_a);
        n = 0;
        while (!(sh_op inside {OP_LSL, OP_LSR, OP_ASR}) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_shift", sh_op, OP_ASR);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = 2'd0;
        bus.cmd_data  = 8'h11;
        bus.cmd_amt   = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_cmd_ready", bus.cmd_ready, 1);
            check("post_rst_sh_op", sh_op, OP_NOP);
            check("post_rst_res_valid", bus.res_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2'd0, 8'h81, 1, acc_a);
        wait_idle();

        check("illegal_sh_op_cycles", illegal, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
